// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake bundle for mem_bus_arbiter: one instance per port (C or V).
// The requester holds req (with we/addr/wdata) until it sees its one-cycle ack.
interface mem_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one async SRAM/ROB bus between ports C and V.
// Each access runs SETUP / STROBE (1+WAIT_STATES cycles) / HOLD; every pin is registered.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    mem_bus_arbiter_if.slave  c,
    mem_bus_arbiter_if.slave  v,
    output logic [15:0]       a,
    inout  wire  [7:0]        d,
    output logic              n_oe,
    output logic              n_we
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic       win_v;      // current access belongs to port V
    logic       last_v;     // last grant went to port V
    logic       we_l;
    logic       d_oe;
    logic [7:0] d_out;
    logic       c_ack_r;
    logic       v_ack_r;
    logic [7:0] c_rdata_r;
    logic [7:0] v_rdata_r;

    logic any_req;
    logic grant_v;

    // V wins when alone, or on a tie when C was served last.
    assign any_req = c.req | v.req;
    assign grant_v = v.req & (~c.req | ~last_v);

    assign d       = d_oe ? d_out : 8'hzz;
    assign c.ack   = c_ack_r;
    assign v.ack   = v_ack_r;
    assign c.rdata = c_rdata_r;
    assign v.rdata = v_rdata_r;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            win_v     <= 1'b0;
            last_v    <= 1'b1;
            we_l      <= 1'b0;
            d_oe      <= 1'b0;
            d_out     <= 8'h00;
            a         <= 16'h0000;
            n_oe      <= 1'b1;
            n_we      <= 1'b1;
            c_ack_r   <= 1'b0;
            v_ack_r   <= 1'b0;
            c_rdata_r <= 8'h00;
            v_rdata_r <= 8'h00;
        end else begin
            c_ack_r <= 1'b0;
            v_ack_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= SETUP;
                        win_v  <= grant_v;
                        last_v <= grant_v;
                        a      <= grant_v ? v.addr  : c.addr;
                        we_l   <= grant_v ? v.we    : c.we;
                        d_out  <= grant_v ? v.wdata : c.wdata;
                        d_oe   <= grant_v ? v.we    : c.we;
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    wait_cnt <= WAIT_INIT;
                    n_oe     <= we_l;
                    n_we     <= ~we_l;
                end
                STROBE: begin
                    if (wait_cnt == 3'd0) begin
                        state <= HOLD;
                        n_oe  <= 1'b1;
                        n_we  <= 1'b1;
                        if (!we_l) begin
                            if (win_v) v_rdata_r <= d;
                            else       c_rdata_r <= d;
                        end
                        if (win_v) v_ack_r <= 1'b1;
                        else       c_ack_r <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                HOLD: begin
                    // Write data stays on d through HOLD for memory hold time.
                    state <= IDLE;
                    d_oe  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset abort, tie rotation, a vector table of
// single-port accesses against a byte-array memory model, and WAIT_STATES 0/7 builds.
module tb_mem_bus_arbiter;

    localparam int W = 1;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- main DUT, WAIT_STATES = 1 ----------------
    mem_bus_arbiter_if c ();
    mem_bus_arbiter_if v ();
    logic [15:0] a;
    wire  [7:0]  d;
    logic        n_oe;
    logic        n_we;
    logic [7:0]  mem [65536];

    mem_bus_arbiter #(.WAIT_STATES(W)) dut (
        .clk(clk), .n_rst(n_rst), .c(c), .v(v), .a(a), .d(d), .n_oe(n_oe), .n_we(n_we)
    );

    assign d = !n_oe ? mem[a] : 8'hzz;
    always @(posedge n_we) if (n_rst) mem[a] <= d;

    // ---------------- WAIT_STATES = 0 and 7 builds ----------------
    mem_bus_arbiter_if c0 ();
    mem_bus_arbiter_if v0 ();
    mem_bus_arbiter_if c7 ();
    mem_bus_arbiter_if v7 ();
    logic [15:0] a0, a7;
    wire  [7:0]  d0, d7;
    logic        n_oe0, n_we0, n_oe7, n_we7;

    mem_bus_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .c(c0), .v(v0), .a(a0), .d(d0), .n_oe(n_oe0), .n_we(n_we0)
    );
    mem_bus_arbiter #(.WAIT_STATES(7)) dut7 (
        .clk(clk), .n_rst(n_rst), .c(c7), .v(v7), .a(a7), .d(d7), .n_oe(n_oe7), .n_we(n_we7)
    );

    assign d0 = !n_oe0 ? 8'h5A : 8'hzz;
    assign d7 = !n_oe7 ? 8'hC3 : 8'hzz;

    // Bus invariants, sampled every cycle away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            check("oe_we_exclusive", {29'd0, !n_oe && !n_we, !n_oe0 && !n_we0, !n_oe7 && !n_we7}, 32'd0);
            check("d_driven_during_read", {31'd0, !n_oe && dut.d_oe}, 32'd0);
            check("both_acks", {31'd0, c.ack && v.ack}, 32'd0);
        end
    end

    typedef struct {
        bit          port_v;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          corrupt;
        logic [7:0]  exp_c;
        logic [7:0]  exp_v;
    } vec_t;

    vec_t vecs [8];

    task automatic do_access(input bit port_v, input bit we, input logic [15:0] addr,
                             input logic [7:0] wdata, input bit corrupt);
        int lat = 0;
        int oe_low = 0;
        int we_low = 0;
        bit a_bad = 0;
        bit d_bad = 0;
        bit ack;
        @(negedge clk);
        if (port_v) begin v.we = we; v.addr = addr; v.wdata = wdata; v.req = 1'b1; end
        else        begin c.we = we; c.addr = addr; c.wdata = wdata; c.req = 1'b1; end
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (!n_oe) oe_low++;
            if (!n_we) we_low++;
            if (a !== addr) a_bad = 1;
            if (we && d !== wdata) d_bad = 1;
            if (corrupt && j == 2) begin
                if (port_v) v.addr = 16'hFFFF; else c.addr = 16'hFFFF;
            end
            ack = port_v ? v.ack : c.ack;
            if (ack) begin
                lat = j;
                c.req = 1'b0;
                v.req = 1'b0;
                break;
            end
        end
        check("ack_latency", lat, 3 + W);
        check("n_oe_low_cycles", oe_low, we ? 0 : 1 + W);
        check("n_we_low_cycles", we_low, we ? 1 + W : 0);
        check("addr_held", {31'd0, a_bad}, 32'd0);
        check("wdata_on_d", {31'd0, d_bad}, 32'd0);
        @(negedge clk);
        check("ack_single_pulse", {30'd0, c.ack, v.ack}, 32'd0);
        check("d_released", {31'd0, dut.d_oe}, 32'd0);
        if (we) check("mem_written", mem[addr], wdata);
    endtask

    initial begin
        int order [4];
        int t_ack [4];
        int n;
        int n_c;
        int n_v;
        int lat0, lat7, oe0, oe7;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h0100] = 8'h01;
        mem[16'h0200] = 8'h02;
        mem[16'h0010] = 8'h11;
        mem[16'hFFFF] = 8'hE7;
        mem[16'h0040] = 8'h77;

        //          port_v we  addr       wdata  corrupt exp_c  exp_v
        vecs[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5, 8'h02};
        vecs[1] = '{1'b1, 1'b1, 16'h8001, 8'h3C, 1'b0, 8'hA5, 8'h02};
        vecs[2] = '{1'b1, 1'b0, 16'h8001, 8'h00, 1'b0, 8'hA5, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 16'h1234, 8'h5B, 1'b0, 8'hA5, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h5B, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 8'h5B, 8'h11};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'hE7, 8'h11};
        vecs[7] = '{1'b0, 1'b0, 16'h0040, 8'h00, 1'b1, 8'h77, 8'h11};

        c.req = 0; c.we = 0; c.addr = 0; c.wdata = 0;
        v.req = 0; v.we = 0; v.addr = 0; v.wdata = 0;
        c0.req = 0; c0.we = 0; c0.addr = 0; c0.wdata = 0;
        v0.req = 0; v0.we = 0; v0.addr = 0; v0.wdata = 0;
        c7.req = 0; c7.we = 0; c7.addr = 0; c7.wdata = 0;
        v7.req = 0; v7.we = 0; v7.addr = 0; v7.wdata = 0;
        n_rst = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_a", a, 16'h0000);
        check("rst_n_oe", n_oe, 1'b1);
        check("rst_n_we", n_we, 1'b1);
        check("rst_acks", {c.ack, v.ack}, 2'b00);
        check("rst_rdata", {c.rdata, v.rdata}, 16'h0000);
        check("rst_d_oe", dut.d_oe, 1'b0);
        n_rst = 1'b1;

        // Reset asserted mid-STROBE of a V write aborts at once
        @(negedge clk);
        v.we = 1'b1; v.addr = 16'h0300; v.wdata = 8'h99; v.req = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_in_strobe", n_we, 1'b0);
        n_rst = 1'b0;
        #1;
        check("abort_n_we", n_we, 1'b1);
        check("abort_d_oe", dut.d_oe, 1'b0);
        check("abort_acks", {c.ack, v.ack}, 2'b00);
        check("abort_a", a, 16'h0000);
        v.req = 1'b0;
        @(negedge clk);
        check("abort_no_write", mem[16'h0300], 8'h00);
        n_rst = 1'b1;

        // Tie right after reset: C, V, C, V with acks 5 cycles apart
        @(negedge clk);
        c.we = 1'b0; c.addr = 16'h0100; c.req = 1'b1;
        v.we = 1'b0; v.addr = 16'h0200; v.req = 1'b1;
        for (int i = 0; i < 4; i++) begin order[i] = 9; t_ack[i] = 0; end
        n = 0; n_c = 0; n_v = 0;
        for (int cyc = 1; cyc <= 60 && n < 4; cyc++) begin
            @(negedge clk);
            if (c.ack) begin
                order[n] = 0; t_ack[n] = cyc; n++; n_c++;
                if (n_c == 2) c.req = 1'b0;
            end
            if (v.ack && n < 4) begin
                order[n] = 1; t_ack[n] = cyc; n++; n_v++;
                if (n_v == 2) v.req = 1'b0;
            end
        end
        c.req = 1'b0; v.req = 1'b0;
        check("tie_order_0", order[0], 0);
        check("tie_order_1", order[1], 1);
        check("tie_order_2", order[2], 0);
        check("tie_order_3", order[3], 1);
        check("tie_first_ack", t_ack[0], 3 + W);
        for (int i = 0; i < 3; i++) check("tie_ack_spacing", t_ack[i + 1] - t_ack[i], 4 + W);
        check("tie_c_rdata", c.rdata, 8'h01);
        check("tie_v_rdata", v.rdata, 8'h02);
        @(negedge clk);

        // Vector table of single-port accesses
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].port_v, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].corrupt);
            check("c_rdata", c.rdata, vecs[i].exp_c);
            check("v_rdata", v.rdata, vecs[i].exp_v);
        end

        // Strobe width for WAIT_STATES = 0 and 7
        @(negedge clk);
        c0.req = 1'b1; c7.req = 1'b1;
        lat0 = 0; lat7 = 0; oe0 = 0; oe7 = 0;
        for (int j = 1; j <= 30 && (lat0 == 0 || lat7 == 0); j++) begin
            @(negedge clk);
            if (!n_oe0) oe0++;
            if (!n_oe7) oe7++;
            if (c0.ack) begin lat0 = j; c0.req = 1'b0; end
            if (c7.ack) begin lat7 = j; c7.req = 1'b0; end
        end
        c0.req = 1'b0; c7.req = 1'b0;
        check("ws0_latency", lat0, 3);
        check("ws7_latency", lat7, 10);
        check("ws0_strobe", oe0, 1);
        check("ws7_strobe", oe7, 8);
        check("ws0_rdata", c0.rdata, 8'h5A);
        check("ws7_rdata", c7.rdata, 8'hC3);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the external asynchronous SRAM/ROM bus (16-bit address, 8-bit bidirectional data, active-low n_oe/n_we) between two requesters: port C (CPU core) and port V (video/DMA fetch engine).
- Arbitrates round-robin, then sequences each access as a setup/strobe/hold cycle with programmable wait states.
- Returns a one-cycle ack and latched read data to the winning port.
- Sits between the cpu top level and the memory pins; the CPU stalls on its ack.

Parameters:
- WAIT_STATES, 1, extra clock cycles the strobe stays active beyond the first (0..7).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- c_req  input  1  port C access request; level, held until c_ack.
- c_we  input  1  port C write (1) / read (0).
- c_addr  input  16  port C address.
- c_wdata  input  8  port C write data.
- c_ack  output  1  one-cycle pulse: port C access complete.
- c_rdata  output  8  port C read data; valid from c_ack cycle until the next port C read completes.
- v_req, v_we, v_addr, v_wdata, v_ack, v_rdata  same directions/widths/meaning for port V.
- a  output  16  memory address.
- d  inout  8  memory data bus; driven only during write cycles, else high-Z.
- n_oe  output  1  memory output enable, active low.
- n_we  output  1  memory write enable, active low.

Behaviour:
- Reset (async, while n_rst=0): state=IDLE, a=16'h0000, d=Z, n_oe=1, n_we=1, c_ack=v_ack=0, c_rdata=v_rdata=8'h00, last_grant=V, so C wins the first tie.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: on an edge with any req=1, pick the winner and latch its addr/we/wdata into internal registers; go to SETUP. With no request, stay in IDLE.
  - Single requester: that port wins.
  - Both requesting: the port not equal to last_grant wins.
  - Update last_grant to the winner.
- SETUP (1 cycle): a=latched addr; n_oe=n_we=1. For writes, d is driven with wdata from this cycle. Next state STROBE, wait counter=WAIT_STATES.
- STROBE (1+WAIT_STATES cycles):
  - Read: n_oe=0, n_we=1, d=Z.
  - Write: n_we=0, n_oe=1, d=wdata.
  - Counter decrements each cycle. When it reaches 0, on the next edge: for a read, capture d into the winner's rdata register; go to HOLD.
- HOLD (1 cycle): n_oe=n_we=1; a unchanged; write data still driven on d (hold time); winner's ack=1. Next state IDLE; d=Z from IDLE onward.
- Access latency: request seen at edge k gives ack high in the cycle after edge k+2+WAIT_STATES. That is 3+WAIT_STATES cycles per access, plus 1 IDLE cycle between back-to-back accesses.
- Requester rules:
  - addr/we/wdata are sampled only at the IDLE grant edge; later changes do not affect the current access.
  - A req still high in the ack cycle is treated as a new request in the following IDLE.
- Arbitration is never preemptive; a losing requester waits at most one full access.
- n_oe and n_we are never low simultaneously.
- d is never driven while n_oe=0.
- All bus outputs are registered (no combinational path from req to pins).
- rdata of the non-winning port never changes.
- rdata is not updated by writes.
- Reset mid-access aborts immediately to reset values; no ack is issued for the aborted access.
- A counter width of 3 bits covers WAIT_STATES up to 7.

Test Plan:
- Reset: hold n_rst=0 mid-STROBE of a write -> n_we=1, d=Z, acks 0 immediately. After release, IDLE with last_grant=V.
- C read, WAIT_STATES=1: c_req with c_addr=16'h1234, memory model returns 8'hA5.
  - a=16'h1234 from SETUP; n_oe low exactly 2 cycles.
  - c_ack pulses once in the 4th cycle after the request edge; c_rdata=8'hA5 and held afterwards.
- V write: v_addr=16'h8001, v_wdata=8'h3C.
  - d=8'h3C from SETUP through HOLD; n_we low 2 cycles.
  - Memory model holds 8'h3C at 16'h8001; v_ack one pulse; v_rdata unchanged.
- Tie after reset: c_req and v_req raised in the same cycle, both held.
  - Grant order is C, V, C, V.
  - Each ack is separated by 5 cycles; no overlapping strobes.
- Input change during access: change c_addr to 16'hFFFF in the STROBE cycle -> a stays at the latched address until IDLE.
- WAIT_STATES=0 and 7 builds: strobe width is 1 and 8 cycles respectively. Assertions on n_oe&n_we mutual exclusion and d high-Z during reads pass throughout.
